tt_um_emern_frontend: RTL and testbench
=======================================

TT_UM_EMERN_FRONTEND -- requirements
Module: tt_um_emern_frontend

Interface
REQ-001 SHALL have parameters from the shared package: WCOLOR=6 (RRGGBB colour), WPX=10 (x coordinate bits), WPY=9 (y coordinate bits), N_POLY=6 (polygon slots).
REQ-002 Ports, in order:
  clk  in  1  system clock; the single clock.
  rst_n  in  1  synchronous, active-low reset.
  cs_in  in  1  SPI chip select, active low, asynchronous to clk.
  mosi_in  in  1  SPI data in, asynchronous to clk.
  sck_in  in  1  SPI clock, mode 0, asynchronous to clk.
  miso_out  out  1  SPI data out.
  en_load  in  1  copy shadow scene to outputs.
  bg_color_out  out  WCOLOR  background colour.
  poly_color_out  out  WCOLOR*N_POLY  per-polygon colour; slot k at bits [WCOLOR*(k+1)-1 : WCOLOR*k].
  v0_x_out, v1_x_out, v2_x_out  out  WPX*N_POLY  vertex x per slot, same slot packing.
  v0_y_out, v1_y_out, v2_y_out  out  WPY*N_POLY  vertex y per slot, same slot packing.
  poly_enable_out  out  N_POLY  bit k enables slot k.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 cs_in, sck_in and mosi_in SHALL each pass through a 2-flop synchronizer; sck rising and falling edges SHALL be detected in the clk domain. Supported sck rate is at most clk/4.
REQ-005 A frame SHALL start on a synchronized cs_in falling edge, which clears the bit counter and shift register. mosi SHALL be sampled on each sck rising edge while cs is low, MSB first.
REQ-006 Each frame SHALL consist of an 8-bit header followed by a payload. Header bits [3:0] SHALL give the index; bits [7:4] SHALL be ignored.
REQ-007 Index 0 (background) SHALL carry an 8-bit payload; bits [5:0] go to shadow background colour.
REQ-008 Index 1..6 (polygon slot index-1) SHALL carry a 64-bit payload, MSB first: enable(1), color(6), v0x(10), v0y(9), v1x(10), v1y(9), v2x(10), v2y(9).
REQ-009 Indices 7..15 SHALL be accepted and SHALL have no effect.
REQ-010 On the synchronized cs_in rising edge, the frame SHALL be committed to the shadow registers only if the received bit count exactly equals 8 + payload length. Frames that are too short or too long SHALL be discarded without effect.
REQ-011 The commit SHALL take effect in the clk cycle after the synchronized cs rise is detected.
REQ-012 When en_load is high at a clk edge, all shadow registers SHALL be copied atomically to the outputs, visible the following cycle. Outputs SHALL otherwise hold their values.
REQ-013 If en_load and a commit occur in the same cycle, the outputs SHALL receive the pre-commit shadow values; the new data appears on the next en_load.
REQ-014 miso_out SHALL shift out the ID byte 0xA5, MSB first, during the header. Each bit SHALL update on an sck falling edge; the first bit SHALL be valid from cs fall. miso_out SHALL be 0 during the payload and while cs is high.
REQ-015 Coordinates SHALL be stored unmodified, with no range clamping.

Reset
REQ-016 While rst_n is low at a clk edge, all outputs, shadow registers, synchronizers, the bit counter and the shift register SHALL clear to 0, and miso_out SHALL be 0.
REQ-017 Reset asserted mid-frame SHALL abort the frame. After reset, reception SHALL resume only at the next cs falling edge.

Structure
REQ-018 The shared package SHALL hold WCOLOR, WPX, WPY, N_POLY, the payload lengths (8 and 64), the index constants and the ID byte 0xA5.
REQ-019 Synchronizer, edge detect, bit counter, shifter and miso logic SHALL live in one sub-module, spi_rx, which reports frame-done, bit count and data. Shadow registers and the output registers SHALL be in the top level.

Verification
REQ-020 Reset, then pulse en_load -> all outputs 0.
REQ-021 Send header 0x00 with payload 0x2A, then pulse en_load -> bg_color_out=6'h2A. Before en_load, bg_color_out remains 0.
REQ-022 Send index 0x03 with payload enable=1, color=6'h3F, v0=(100,50), v1=(639,0), v2=(0,479), then pulse en_load -> slot 2 fields equal these values, poly_enable_out=6'b000100, other slots 0.
REQ-023 Send index 0x01 frame truncated after 40 bits, and a 0x01 frame with 73 bits -> no change after en_load.
REQ-024 Drive en_load in the same cycle as a commit -> outputs unchanged; a second en_load shows the new data.
REQ-025 During any header, sample miso_out on sck rising edges -> 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/tt_um_emern_frontend_pkg.sv
// Shared widths, frame layout constants and the polygon record layout for the
// SPI scene-loading front end.
package tt_um_emern_frontend_pkg;

  localparam int WCOLOR = 6;
  localparam int WPX    = 10;
  localparam int WPY    = 9;
  localparam int N_POLY = 6;

  localparam int HDR_LEN          = 8;
  localparam int BG_PAYLOAD_LEN   = 8;
  localparam int POLY_PAYLOAD_LEN = 64;
  localparam int FRAME_MAX        = HDR_LEN + POLY_PAYLOAD_LEN;
  localparam int CNT_W            = 7;

  localparam logic [3:0] IDX_BG         = 4'd0;
  localparam logic [3:0] IDX_POLY_FIRST = 4'd1;
  localparam logic [3:0] IDX_POLY_LAST  = 4'd6;

  localparam logic [7:0] ID_BYTE = 8'hA5;

  // Polygon payload as it arrives, MSB first.
  typedef struct packed {
    logic              en;
    logic [WCOLOR-1:0] color;
    logic [WPX-1:0]    v0x;
    logic [WPY-1:0]    v0y;
    logic [WPX-1:0]    v1x;
    logic [WPY-1:0]    v1y;
    logic [WPX-1:0]    v2x;
    logic [WPY-1:0]    v2y;
  } poly_rec_t;

endpackage

// File: rtl/tt_um_emern_frontend_spi_rx.sv
// SPI mode-0 receiver in the clk domain: synchronizers, edge detection, bit
// counter, shift register and the ID-byte miso driver.
module spi_rx
  import tt_um_emern_frontend_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_in,
  input  logic                 sck_in,
  input  logic                 mosi_in,
  output logic                 miso,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic [FRAME_MAX-1:0] data
);

  logic [1:0] cs_sync;
  logic [1:0] sck_sync;
  logic [1:0] mosi_sync;
  logic       cs_prev;
  logic       sck_prev;
  logic       active;

  logic cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_s     = cs_sync[1];
  assign sck_s    = sck_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;

  // active is only set by a cs fall, so a frame cut by reset is never resumed.
  assign frame_done = cs_rise & active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b0;
      sck_prev  <= 1'b0;
      active    <= 1'b0;
      bit_cnt   <= '0;
      data      <= '0;
      miso      <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_in};
      sck_sync  <= {sck_sync[0], sck_in};
      mosi_sync <= {mosi_sync[0], mosi_in};
      cs_prev   <= cs_s;
      sck_prev  <= sck_s;
      if (cs_fall) begin
        active  <= 1'b1;
        bit_cnt <= '0;
        data    <= '0;
        miso    <= ID_BYTE[7];
      end else if (active) begin
        if (cs_rise) begin
          active <= 1'b0;
          miso   <= 1'b0;
        end else begin
          if (sck_rise) begin
            data <= {data[FRAME_MAX-2:0], mosi_s};
            // Saturate so overlong frames can never wrap back to a valid length.
            if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
          end
          if (sck_fall) begin
            if (bit_cnt < CNT_W'(HDR_LEN)) miso <= ID_BYTE[3'd7 - bit_cnt[2:0]];
            else                           miso <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tt_um_emern_frontend.sv
// Scene front end: frames received over SPI land in shadow registers and are
// copied to the registered scene outputs atomically on en_load.
module tt_um_emern_frontend
  import tt_um_emern_frontend_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs_in,
  input  logic                     mosi_in,
  input  logic                     sck_in,
  output logic                     miso_out,
  input  logic                     en_load,
  output logic [WCOLOR-1:0]        bg_color_out,
  output logic [WCOLOR*N_POLY-1:0] poly_color_out,
  output logic [WPX*N_POLY-1:0]    v0_x_out,
  output logic [WPX*N_POLY-1:0]    v1_x_out,
  output logic [WPX*N_POLY-1:0]    v2_x_out,
  output logic [WPY*N_POLY-1:0]    v0_y_out,
  output logic [WPY*N_POLY-1:0]    v1_y_out,
  output logic [WPY*N_POLY-1:0]    v2_y_out,
  output logic [N_POLY-1:0]        poly_enable_out
);

  logic                 frame_done;
  logic [CNT_W-1:0]     rx_cnt;
  logic [FRAME_MAX-1:0] rx_data;

  spi_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_in      (cs_in),
    .sck_in     (sck_in),
    .mosi_in    (mosi_in),
    .miso       (miso_out),
    .frame_done (frame_done),
    .bit_cnt    (rx_cnt),
    .data       (rx_data)
  );

  logic            len_bg, len_poly;
  logic [7:0]      hdr;
  logic [3:0]      idx;
  poly_rec_t       rec;
  logic            commit_bg, commit_poly;
  logic            unused_hdr_bits;

  // The header sits just above the payload, so its position follows the length.
  always_comb begin
    len_bg      = (rx_cnt == CNT_W'(HDR_LEN + BG_PAYLOAD_LEN));
    len_poly    = (rx_cnt == CNT_W'(HDR_LEN + POLY_PAYLOAD_LEN));
    hdr         = len_bg ? rx_data[15:8] : rx_data[FRAME_MAX-1:POLY_PAYLOAD_LEN];
    idx         = hdr[3:0];
    rec         = rx_data[POLY_PAYLOAD_LEN-1:0];
    commit_bg   = frame_done && len_bg && (idx == IDX_BG);
    commit_poly = frame_done && len_poly &&
                  (idx >= IDX_POLY_FIRST) && (idx <= IDX_POLY_LAST);
  end

  assign unused_hdr_bits = ^{hdr[7:4]};

  logic [WCOLOR-1:0]        sh_bg;
  logic [WCOLOR*N_POLY-1:0] sh_color;
  logic [WPX*N_POLY-1:0]    sh_v0x, sh_v1x, sh_v2x;
  logic [WPY*N_POLY-1:0]    sh_v0y, sh_v1y, sh_v2y;
  logic [N_POLY-1:0]        sh_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_bg    <= '0;
      sh_color <= '0;
      sh_v0x   <= '0;
      sh_v1x   <= '0;
      sh_v2x   <= '0;
      sh_v0y   <= '0;
      sh_v1y   <= '0;
      sh_v2y   <= '0;
      sh_en    <= '0;
    end else begin
      if (commit_bg) sh_bg <= rx_data[WCOLOR-1:0];
      for (int k = 0; k < N_POLY; k++) begin
        if (commit_poly && (idx == 4'(k + 1))) begin
          sh_en[k]                     <= rec.en;
          sh_color[k*WCOLOR +: WCOLOR] <= rec.color;
          sh_v0x[k*WPX +: WPX]         <= rec.v0x;
          sh_v0y[k*WPY +: WPY]         <= rec.v0y;
          sh_v1x[k*WPX +: WPX]         <= rec.v1x;
          sh_v1y[k*WPY +: WPY]         <= rec.v1y;
          sh_v2x[k*WPX +: WPX]         <= rec.v2x;
          sh_v2y[k*WPY +: WPY]         <= rec.v2y;
        end
      end
    end
  end

  // Reads the shadow before this edge's commit lands, so a coincident
  // en_load publishes the previous scene.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bg_color_out    <= '0;
      poly_color_out  <= '0;
      v0_x_out        <= '0;
      v1_x_out        <= '0;
      v2_x_out        <= '0;
      v0_y_out        <= '0;
      v1_y_out        <= '0;
      v2_y_out        <= '0;
      poly_enable_out <= '0;
    end else if (en_load) begin
      bg_color_out    <= sh_bg;
      poly_color_out  <= sh_color;
      v0_x_out        <= sh_v0x;
      v1_x_out        <= sh_v1x;
      v2_x_out        <= sh_v2x;
      v0_y_out        <= sh_v0y;
      v1_y_out        <= sh_v1y;
      v2_y_out        <= sh_v2y;
      poly_enable_out <= sh_en;
    end
  end

endmodule

// File: tb/tb_tt_um_emern_frontend.sv
// Directed bench for the SPI scene front end: background and polygon frames,
// length rejection, en_load/commit collision, mid-frame reset and ID byte.
module tb_tt_um_emern_frontend;

  logic        clk = 1'b0;
  logic        rst_n, cs_in, mosi_in, sck_in, en_load;
  logic        miso_out;
  logic [5:0]  bg_color_out;
  logic [35:0] poly_color_out;
  logic [59:0] v0_x_out, v1_x_out, v2_x_out;
  logic [53:0] v0_y_out, v1_y_out, v2_y_out;
  logic [5:0]  poly_enable_out;

  int total = 0;
  int bad   = 0;

  logic [5:0]  exp_bg, exp_en;
  logic [35:0] exp_color;
  logic [59:0] exp_v0x, exp_v1x, exp_v2x;
  logic [53:0] exp_v0y, exp_v1y, exp_v2y;

  logic [7:0]  mh;
  logic        mp;
  logic [71:0] frame;

  tt_um_emern_frontend dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cs_in           (cs_in),
    .mosi_in         (mosi_in),
    .sck_in          (sck_in),
    .miso_out        (miso_out),
    .en_load         (en_load),
    .bg_color_out    (bg_color_out),
    .poly_color_out  (poly_color_out),
    .v0_x_out        (v0_x_out),
    .v1_x_out        (v1_x_out),
    .v2_x_out        (v2_x_out),
    .v0_y_out        (v0_y_out),
    .v1_y_out        (v1_y_out),
    .v2_y_out        (v2_y_out),
    .poly_enable_out (poly_enable_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":bg"},    64'(bg_color_out),    64'(exp_bg));
    chk({tag, ":en"},    64'(poly_enable_out), 64'(exp_en));
    chk({tag, ":color"}, 64'(poly_color_out),  64'(exp_color));
    chk({tag, ":v0x"},   64'(v0_x_out),        64'(exp_v0x));
    chk({tag, ":v0y"},   64'(v0_y_out),        64'(exp_v0y));
    chk({tag, ":v1x"},   64'(v1_x_out),        64'(exp_v1x));
    chk({tag, ":v1y"},   64'(v1_y_out),        64'(exp_v1y));
    chk({tag, ":v2x"},   64'(v2_x_out),        64'(exp_v2x));
    chk({tag, ":v2y"},   64'(v2_y_out),        64'(exp_v2y));
  endtask

  // sck half-period is 4 clk cycles; miso is sampled right at each sck rise.
  task automatic spi_send(input logic [79:0] bits, input int n, input bit start,
                          output logic [7:0] miso_hdr, output logic miso_pay);
    miso_hdr = '0;
    miso_pay = 1'b0;
    @(negedge clk);
    if (start) cs_in = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi_in = bits[n-1-i];
      repeat (4) @(negedge clk);
      if (i < 8) miso_hdr[7-i] = miso_out;
      else       miso_pay = miso_pay | miso_out;
      sck_in = 1'b1;
      repeat (4) @(negedge clk);
      sck_in = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_in   = 1'b1;
    mosi_in = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    en_load = 1'b1;
    @(negedge clk);
    en_load = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cs_in = 1'b1; mosi_in = 1'b0; sck_in = 1'b0; en_load = 1'b0;
    exp_bg = '0; exp_en = '0; exp_color = '0;
    exp_v0x = '0; exp_v1x = '0; exp_v2x = '0;
    exp_v0y = '0; exp_v1y = '0; exp_v2y = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset:miso", 64'(miso_out), 64'd0);
    rst_n = 1'b1;
    pulse_load();
    check_outputs("load_after_reset");

    // Background frame; outputs wait for en_load
    spi_send(80'h002A, 16, 1'b1, mh, mp);
    chk("bg:miso_hdr", 64'(mh), 64'hA5);
    chk("bg:miso_pay", 64'(mp), 64'd0);
    settle();
    chk("bg:miso_idle", 64'(miso_out), 64'd0);
    chk("bg:before_load", 64'(bg_color_out), 64'd0);
    pulse_load();
    exp_bg = 6'h2A;
    check_outputs("bg_load");

    // Polygon slot 2 via index 3, coordinates at their extremes
    frame = {8'h03, 1'b1, 6'h3F, 10'd100, 9'd50, 10'd639, 9'd0, 10'd0, 9'd479};
    spi_send(80'(frame), 72, 1'b1, mh, mp);
    chk("poly:miso_hdr", 64'(mh), 64'hA5);
    chk("poly:miso_pay", 64'(mp), 64'd0);
    settle();
    pulse_load();
    exp_en           = 6'b000100;
    exp_color[12+:6] = 6'h3F;
    exp_v0x[20+:10]  = 10'd100;
    exp_v0y[18+:9]   = 9'd50;
    exp_v1x[20+:10]  = 10'd639;
    exp_v2y[18+:9]   = 9'd479;
    check_outputs("poly_load");

    // Wrong-length frames for slot 0 and an inert index are all discarded
    frame = {8'h01, 1'b1, 6'h11, 10'd5, 9'd6, 10'd7, 9'd8, 10'd9, 9'd10};
    spi_send(80'(frame >> 32), 40, 1'b1, mh, mp);
    chk("short:miso_hdr", 64'(mh), 64'hA5);
    settle();
    spi_send({7'd0, frame, 1'b1}, 73, 1'b1, mh, mp);
    chk("long:miso_hdr", 64'(mh), 64'hA5);
    settle();
    frame[71:64] = 8'h09;
    spi_send(80'(frame), 72, 1'b1, mh, mp);
    settle();
    spi_send(80'h0F3F, 16, 1'b1, mh, mp);
    settle();
    pulse_load();
    check_outputs("discarded");

    // en_load lands on the commit edge; header upper nibble is ignored
    spi_send(80'hA015, 16, 1'b1, mh, mp);
    repeat (2) @(negedge clk);
    en_load = 1'b1;
    @(negedge clk);
    en_load = 1'b0;
    @(negedge clk);
    check_outputs("coincident_load");
    pulse_load();
    exp_bg = 6'h15;
    check_outputs("second_load");

    // Reset mid-frame; bits clocked with cs still low must not form a frame
    @(negedge clk);
    cs_in = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_bg = '0; exp_en = '0; exp_color = '0;
    exp_v0x = '0; exp_v1x = '0; exp_v2x = '0;
    exp_v0y = '0; exp_v1y = '0; exp_v2y = '0;
    check_outputs("mid_reset");
    spi_send(80'h003F, 16, 1'b0, mh, mp);
    settle();
    pulse_load();
    check_outputs("after_abort");

    // Reception resumes at the next cs fall
    spi_send(80'h0007, 16, 1'b1, mh, mp);
    chk("resume:miso_hdr", 64'(mh), 64'hA5);
    settle();
    pulse_load();
    exp_bg = 6'h07;
    check_outputs("resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
